// File: rtl/debounce_pkg.sv
// Shared FSM state encoding and default parameters for the debounce/edge-detect block.
package debounce_pkg;

    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_STABLE_CNT  = 50000;
    localparam int unsigned DEF_CNT_WIDTH   = 16;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        WAIT_HI   = 2'b01,
        STABLE_HI = 2'b10,
        WAIT_LO   = 2'b11
    } state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single-bit asynchronous level; resets every stage to RST_VAL.
module sync_ff #(
    parameter int unsigned DEPTH   = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {DEPTH{RST_VAL}};
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/debounce_edge_detect.sv
// Synchronise, debounce and edge-detect a raw asynchronous level.
// Define DEBOUNCE_FALL_PULSE_EN to enable the fall pulse; otherwise fall is tied low.
module debounce_edge_detect
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CNT  = DEF_STABLE_CNT,
    parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter logic        INIT_Q      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic D,
    output logic Q,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CNT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 d_s;
    state_e               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 q_q;
    logic                 rise_q;
`ifdef DEBOUNCE_FALL_PULSE_EN
    logic                 fall_q;
`endif

    sync_ff #(
        .DEPTH   (SYNC_STAGES),
        .RST_VAL (INIT_Q)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (D),
        .q_o   (d_s)
    );

    // A new level is accepted only after STABLE_CNT consecutive matching samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT_Q ? STABLE_HI : STABLE_LO;
            cnt_q   <= '0;
            q_q     <= INIT_Q;
            rise_q  <= 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
            fall_q  <= 1'b0;
`endif
        end else begin
            rise_q <= 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
            fall_q <= 1'b0;
`endif
            case (state_q)
                STABLE_LO: begin
                    if (d_s) begin
                        state_q <= WAIT_HI;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                WAIT_HI: begin
                    if (!d_s) begin
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= STABLE_HI;
                        cnt_q   <= '0;
                        q_q     <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!d_s) begin
                        state_q <= WAIT_LO;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                WAIT_LO: begin
                    if (d_s) begin
                        state_q <= STABLE_HI;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                        q_q     <= 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
                        fall_q  <= 1'b1;
`endif
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
            endcase
        end
    end

    assign Q    = q_q;
    assign rise = rise_q;
`ifdef DEBOUNCE_FALL_PULSE_EN
    assign fall = fall_q;
`else
    assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Directed self-checking bench for debounce_edge_detect (STABLE_CNT=4, SYNC_STAGES=2, 100 ns clock).
module tb_debounce_edge_detect;

`ifdef DEBOUNCE_FALL_PULSE_EN
    localparam logic EXP_FALL = 1'b1;
`else
    localparam logic EXP_FALL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic D;
    logic Q, rise, fall;
    logic D1;
    logic Q1, rise1, fall1;
    logic pulse1_seen = 1'b0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    debounce_edge_detect #(
        .SYNC_STAGES (2),
        .STABLE_CNT  (4),
        .CNT_WIDTH   (16),
        .INIT_Q      (1'b0)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .D     (D),
        .Q     (Q),
        .rise  (rise),
        .fall  (fall)
    );

    debounce_edge_detect #(
        .SYNC_STAGES (2),
        .STABLE_CNT  (4),
        .CNT_WIDTH   (16),
        .INIT_Q      (1'b1)
    ) u_dut_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .D     (D1),
        .Q     (Q1),
        .rise  (rise1),
        .fall  (fall1)
    );

    always #50 clk = ~clk;

    // Sticky record of any pulse from the INIT_Q=1 instance.
    always @(negedge clk) begin
        if (rise1 || fall1) pulse1_seen = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        D     = 1'b0;
        D1    = 1'b1;
        #120;
        total_cnt++;
        if ({Q, rise, fall} !== 3'b000) $display("FAIL reset_lo: got %b want 000", {Q, rise, fall});
        else pass_cnt++;
        total_cnt++;
        if ({Q1, rise1, fall1} !== 3'b100) $display("FAIL reset_hi: got %b want 100", {Q1, rise1, fall1});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_rise();
        step();
        D = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step();
            total_cnt++;
            if ({Q, rise, fall} !== 3'b000) $display("FAIL rise_wait edge %0d: got %b want 000", e, {Q, rise, fall});
            else pass_cnt++;
        end
        step();
        total_cnt++;
        if ({Q, rise, fall} !== 3'b110) $display("FAIL rise_edge6: got %b want 110", {Q, rise, fall});
        else pass_cnt++;
        step();
        total_cnt++;
        if ({Q, rise, fall} !== 3'b100) $display("FAIL rise_edge7: got %b want 100", {Q, rise, fall});
        else pass_cnt++;
    endtask

    task automatic test_fall();
        step();
        D = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            step();
            total_cnt++;
            if ({Q, rise, fall} !== 3'b100) $display("FAIL fall_wait edge %0d: got %b want 100", e, {Q, rise, fall});
            else pass_cnt++;
        end
        step();
        total_cnt++;
        if ({Q, rise, fall} !== {2'b00, EXP_FALL}) $display("FAIL fall_edge6: got %b want %b", {Q, rise, fall}, {2'b00, EXP_FALL});
        else pass_cnt++;
        step();
        total_cnt++;
        if ({Q, rise, fall} !== 3'b000) $display("FAIL fall_edge7: got %b want 000", {Q, rise, fall});
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        step();
        D = 1'b1;
        repeat (3) step();
        D = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            step();
            total_cnt++;
            if ({Q, rise, fall} !== 3'b000) $display("FAIL glitch edge %0d: got %b want 000", e, {Q, rise, fall});
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_wait();
        step();
        D = 1'b1;
        repeat (4) step();
        total_cnt++;
        if (u_dut.cnt_q !== 16'd2) $display("FAIL mid_wait_cnt: got %0d want 2", u_dut.cnt_q);
        else pass_cnt++;
        #20;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({Q, rise, fall} !== 3'b000 || u_dut.cnt_q !== 16'd0)
            $display("FAIL mid_wait_reset: got qrf=%b cnt=%0d want 000 cnt=0", {Q, rise, fall}, u_dut.cnt_q);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step();
            total_cnt++;
            if ({Q, rise, fall} !== 3'b000) $display("FAIL post_reset_wait edge %0d: got %b want 000", e, {Q, rise, fall});
            else pass_cnt++;
        end
        step();
        total_cnt++;
        if ({Q, rise, fall} !== 3'b110) $display("FAIL post_reset_edge6: got %b want 110", {Q, rise, fall});
        else pass_cnt++;
        step();
    endtask

    task automatic test_toggle();
        for (int e = 1; e <= 20; e++) begin
            step();
            D = ~D;
            total_cnt++;
            if ({Q, rise, fall} !== 3'b100) $display("FAIL toggle edge %0d: got %b want 100", e, {Q, rise, fall});
            else pass_cnt++;
        end
        D = 1'b1;
        repeat (6) step();
        total_cnt++;
        if ({Q, rise, fall} !== 3'b100) $display("FAIL toggle_settle: got %b want 100", {Q, rise, fall});
        else pass_cnt++;
    endtask

    task automatic test_init_high();
        total_cnt++;
        if (Q1 !== 1'b1) $display("FAIL init_high_q: got %b want 1", Q1);
        else pass_cnt++;
        total_cnt++;
        if (pulse1_seen !== 1'b0) $display("FAIL init_high_pulse: got %b want 0", pulse1_seen);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_rise();
        test_fall();
        test_glitch();
        test_reset_mid_wait();
        test_toggle();
        test_init_high();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/debounce_edge_detect.md
DEBOUNCE_EDGE_DETECT -- requirements
Module: debounce_edge_detect

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, number of input synchroniser flops (legal 2..4).
REQ-002 The block SHALL have parameter STABLE_CNT, default 50000, consecutive synchronised samples required to accept a new level (legal 2..2^CNT_WIDTH-1).
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16, stability counter width.
REQ-004 The block SHALL have parameter INIT_Q, default 1'b0, level of Q and of all synchroniser flops after reset.
REQ-005 The block SHALL have port clk, input, 1 bit, single clock; all flops on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-007 The block SHALL have port D, input, 1 bit, raw asynchronous level (switch/button or foreign-domain signal).
REQ-008 The block SHALL have port Q, output, 1 bit, registered debounced level that feeds the downstream positive-edge flip-flop stage.
REQ-009 The block SHALL have port rise, output, 1 bit, one-cycle pulse when Q goes 0->1.
REQ-010 The block SHALL have port fall, output, 1 bit, one-cycle pulse when Q goes 1->0 (see Configuration).

Function
REQ-011 D SHALL pass through a SYNC_STAGES-deep flop chain; its last stage is d_s; no other logic SHALL sample D.
REQ-012 The FSM SHALL have states STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-013 In STABLE_LO with d_s=1, the FSM SHALL go to WAIT_HI with cnt=1; with d_s=0, it SHALL stay with cnt=0.
REQ-014 In WAIT_HI with d_s=0, the FSM SHALL return to STABLE_LO with cnt=0 and produce no pulse (glitch rejected).
REQ-015 In WAIT_HI with d_s=1 and cnt<STABLE_CNT-1, cnt SHALL increment.
REQ-016 In WAIT_HI with d_s=1 and cnt=STABLE_CNT-1, the FSM SHALL go to STABLE_HI, Q<=1, rise<=1, cnt<=0.
REQ-017 STABLE_HI and WAIT_LO SHALL mirror REQ-013..016 with levels inverted, ending with Q<=0 and fall<=1.
REQ-018 Latency: with D held high from before edge 1, Q and rise SHALL assert after edge SYNC_STAGES+STABLE_CNT, exactly; falling is symmetric.
REQ-019 rise and fall SHALL be high for exactly one cycle and SHALL never be high together.
REQ-020 Q SHALL change only on REQ-016/017 transitions; cnt SHALL never exceed STABLE_CNT-1 or wrap.
REQ-021 A D pulse shorter than STABLE_CNT synchronised samples SHALL leave Q, rise and fall unchanged.

Reset
REQ-022 On rst_n=0, the block SHALL immediately, without a clock, set: synchroniser flops=INIT_Q, Q=INIT_Q, rise=0, fall=0, cnt=0, state=STABLE_HI if INIT_Q else STABLE_LO.
REQ-023 Reset asserted mid-WAIT_* SHALL abandon the count; no pulse SHALL be generated on reset entry or exit.
REQ-024 After rst_n deasserts, if D differs from INIT_Q, a full REQ-018 qualification SHALL occur before Q changes.

Configuration
REQ-025 Macro DEBOUNCE_FALL_PULSE_EN defined: fall SHALL behave per REQ-017/019.
REQ-026 Macro DEBOUNCE_FALL_PULSE_EN undefined: the fall port SHALL remain present and be tied to constant 0; Q and rise are unaffected.

Structure
REQ-027 Package debounce_pkg SHALL hold the FSM state typedef (2-bit encoding) and the default constants for SYNC_STAGES, STABLE_CNT and CNT_WIDTH.
REQ-028 The synchroniser SHALL be a sub-module sync_ff, parameterised by depth and reset value, with async active-low reset.
REQ-029 The FSM, the counter and the output registers SHALL reside in debounce_edge_detect; no combinational path SHALL exist from D to any output.

Verification (STABLE_CNT=4, SYNC_STAGES=2, INIT_Q=0, 100 ns clk)
REQ-030 Bench: D 0->1 held -> Q=1 and rise=1 after edge 6 exactly, rise=0 at edge 7.
REQ-031 Bench: D high for 3 edges then low -> Q stays 0, no rise/fall pulse.
REQ-032 Bench: with Q=1, D 1->0 held -> Q=0 after edge 6; fall pulses 1 cycle with macro, fall stays 0 without macro.
REQ-033 Bench: rst_n low mid-WAIT_HI (cnt=2) between edges -> Q=0 and cnt=0 at once; after release with D=1, Q rises 6 edges later.
REQ-034 Bench: INIT_Q=1, D=1 through reset -> Q=1 from reset, no rise pulse ever.
REQ-035 Bench: D alternating every edge for 20 edges -> Q constant, rise/fall never asserted.
